ram_64_arbiter: RTL and testbench

//   Shares one 64 x 16 word RAM between two requesters, A and B.

---
 rtl/ram_64_arbiter.sv | 105 ++++++++++
 tb/tb_ram_64_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_64_arbiter.sv
// ram_64_arbiter: round-robin A/B arbiter for one 64x16 RAM port; define RAM64_CLEAR_EN for a post-reset zero sweep
module ram_64_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy
);
    typedef enum logic [1:0] {CLEAR, IDLE, WRITE, RDWAIT} state_t;
    state_t state, state_nx;
    logic pick_b, sel_we, done, gnt_b, last_b;
    logic [1:0] cnt;
`ifdef RAM64_CLEAR_EN
    localparam state_t RST_STATE = CLEAR;
    logic [ADDR_W:0] clr_addr;
`else
    localparam state_t RST_STATE = IDLE;
    assign busy = 1'b0;
`endif
    // on a tie the requester not granted last wins
    assign pick_b = b_req & (~a_req | ~last_b);
    assign sel_we = pick_b ? b_we : a_we;
    assign done = a_ack | b_ack;
    always_comb begin
        state_nx = (state == IDLE) ? ((a_req | b_req) ? (sel_we ? WRITE : RDWAIT) : IDLE) :
                   (state == WRITE) ? IDLE :
                   (state == RDWAIT) ? (done ? IDLE : RDWAIT) :
`ifdef RAM64_CLEAR_EN
                   (clr_addr[ADDR_W] ? IDLE : CLEAR);
`else
                   IDLE;
`endif
    end
    always_ff @(posedge clk) begin
        if (!reset_n) state <= RST_STATE;
        else state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            ram_address <= '0;
            ram_in      <= '0;
            ram_load    <= 1'b0;
            last_b      <= 1'b1;
            gnt_b       <= 1'b0;
            cnt         <= '0;
`ifdef RAM64_CLEAR_EN
            busy        <= 1'b1;
            clr_addr    <= '0;
`endif
        end else begin
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            ram_load <= 1'b0;
            if (state == IDLE && (a_req | b_req)) begin
                gnt_b       <= pick_b;
                last_b      <= pick_b;
                ram_address <= pick_b ? b_addr : a_addr;
                ram_in      <= pick_b ? b_wdata : a_wdata;
                ram_load    <= sel_we;
                a_ack       <= sel_we & ~pick_b;
                b_ack       <= sel_we & pick_b;
                cnt         <= '0;
            end else if (state == RDWAIT && !done) begin
                cnt <= cnt + 2'd1;
                if (cnt == 2'(RD_LAT - 1)) begin
                    if (gnt_b) b_rdata <= ram_out;
                    else a_rdata <= ram_out;
                    a_ack <= ~gnt_b;
                    b_ack <= gnt_b;
                end
            end
`ifdef RAM64_CLEAR_EN
            else if (state == CLEAR) begin
                busy        <= ~clr_addr[ADDR_W];
                ram_load    <= ~clr_addr[ADDR_W];
                ram_address <= clr_addr[ADDR_W-1:0];
                ram_in      <= '0;
                clr_addr    <= clr_addr + (ADDR_W+1)'(1);
            end
`endif
        end
    end
endmodule

// File: tb/tb_ram_64_arbiter.sv
// tb_ram_64_arbiter: directed checks of arbitration, read/write timing, reset abort and optional clear sweep
module tb_ram_64_arbiter;
    logic clk = 1'b0, reset_n = 1'b0;
    logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [5:0] a_addr = 0, b_addr = 0;
    logic [15:0] a_wdata = 0, b_wdata = 0;
    logic a_ack, b_ack, ram_load, busy;
    logic [15:0] a_rdata, b_rdata, ram_in, ram_out;
    logic [5:0] ram_address;
    logic [15:0] mem [64];
    int checks = 0, errors = 0;
`ifdef RAM64_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
    assign ram_out = mem[ram_address];

    ram_64_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out), .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input bit sb, input bit we, input logic [5:0] ad, input logic [15:0] wd,
                       output int lat, output logic [15:0] rd, output int loads);
        if (sb) {b_req, b_we, b_addr, b_wdata} = {1'b1, we, ad, wd};
        else {a_req, a_we, a_addr, a_wdata} = {1'b1, we, ad, wd};
        lat = -1;
        rd = '0;
        loads = 0;
        for (int i = 1; i <= 10 && lat < 0; i++) begin
            tick;
            loads += int'(ram_load);
            if (sb ? b_ack : a_ack) begin
                lat = i;
                rd = sb ? b_rdata : a_rdata;
            end
        end
        a_req = 0;
        b_req = 0;
        tick;
        loads += int'(ram_load);
    endtask

    task automatic do_reset;
        a_req = 0;
        b_req = 0;
        reset_n = 0;
        tick;
        tick;
        reset_n = 1;
        tick;
        for (int i = 0; i < 100 && busy; i++) tick;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_timeout got %b want 0", busy);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({a_ack, b_ack, a_rdata, b_rdata, ram_address, ram_in, ram_load} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {a_ack, b_ack, a_rdata, b_rdata, ram_address, ram_in, ram_load});
        end
        checks++;
        if (busy !== CLR) begin
            errors++;
            $display("FAIL reset_busy got %b want %b", busy, CLR);
        end
    endtask

    task automatic test_clear;
        int bc = 0, lc = 0, ac = 0, lat = -1;
        logic [15:0] rd = '0;
        int ld;
        a_req = 1;
        a_we = 0;
        a_addr = 0;
        reset_n = 1;
        for (int i = 0; i < 200; i++) begin
            tick;
            if (!busy) break;
            bc++;
            lc += int'(ram_load);
            ac += int'(a_ack);
        end
        checks++;
        if (bc !== 64) begin errors++; $display("FAIL clear_busy_cycles got %0d want 64", bc); end
        checks++;
        if (lc !== 64) begin errors++; $display("FAIL clear_loads got %0d want 64", lc); end
        checks++;
        if (ac !== 0) begin errors++; $display("FAIL clear_ack_while_busy got %0d want 0", ac); end
        for (int i = 1; i <= 6 && lat < 0; i++) begin
            tick;
            if (a_ack) begin lat = i; rd = a_rdata; end
        end
        a_req = 0;
        tick;
        checks++;
        if (lat !== 2 || rd !== 16'h0000) begin
            errors++;
            $display("FAIL clear_read0 got lat %0d data %h want lat 2 data 0000", lat, rd);
        end
        txn(0, 0, 6'd31, 16'h0, lat, rd, ld);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL clear_read31 got %h want 0000", rd); end
        txn(1, 0, 6'd63, 16'h0, lat, rd, ld);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL clear_read63 got %h want 0000", rd); end
    endtask

    task automatic test_write_read;
        int lat, ld;
        logic [15:0] rd;
        txn(0, 1, 6'd5, 16'h1234, lat, rd, ld);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL wr_ack_latency got %0d want 1", lat); end
        checks++;
        if (ld !== 1) begin errors++; $display("FAIL wr_load_cycles got %0d want 1", ld); end
        txn(0, 0, 6'd5, 16'h0, lat, rd, ld);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL rd_ack_latency got %0d want 2", lat); end
        checks++;
        if (rd !== 16'h1234) begin errors++; $display("FAIL rd_data got %h want 1234", rd); end
        checks++;
        if (ld !== 0) begin errors++; $display("FAIL rd_load_cycles got %0d want 0", ld); end
    endtask

    task automatic test_contention;
        int la = -1, lb = -1, both = 0, lat, ld;
        logic [15:0] rd;
        do_reset;
        {a_req, a_we, a_addr, a_wdata} = {1'b1, 1'b1, 6'd10, 16'h0001};
        {b_req, b_we, b_addr, b_wdata} = {1'b1, 1'b1, 6'd10, 16'h0002};
        for (int i = 1; i <= 12; i++) begin
            tick;
            both += int'(a_ack & b_ack);
            if (a_ack) begin if (la < 0) la = i; a_req = 0; end
            if (b_ack) begin if (lb < 0) lb = i; b_req = 0; end
        end
        checks++;
        if (la !== 1) begin errors++; $display("FAIL tie_a_ack_cycle got %0d want 1", la); end
        checks++;
        if (lb !== 3) begin errors++; $display("FAIL tie_b_ack_cycle got %0d want 3", lb); end
        checks++;
        if (both !== 0) begin errors++; $display("FAIL tie_dual_ack got %0d want 0", both); end
        txn(0, 0, 6'd10, 16'h0, lat, rd, ld);
        checks++;
        if (rd !== 16'h0002) begin errors++; $display("FAIL tie_readback got %h want 0002", rd); end
    endtask

    task automatic test_alternate;
        int na = 0, nb = 0, last_i = -1, lat, ld;
        logic [15:0] rd, exp_b = 16'h0;
        logic nxt_b = 1'b0;
        do_reset;
        txn(0, 1, 6'd1, 16'hAAAA, lat, rd, ld);
        txn(1, 1, 6'd2, 16'h5555, lat, rd, ld);
        {a_req, a_we, a_addr} = {1'b1, 1'b0, 6'd1};
        {b_req, b_we, b_addr} = {1'b1, 1'b0, 6'd2};
        for (int i = 1; i <= 100 && (na < 8 || nb < 8); i++) begin
            tick;
            if (a_ack && b_ack) begin
                checks++;
                errors++;
                $display("FAIL alt_dual_ack at cycle %0d got both want one", i);
            end else if (a_ack || b_ack) begin
                last_i = i;
                checks++;
                if (b_ack !== nxt_b) begin errors++; $display("FAIL alt_order got b=%b want b=%b", b_ack, nxt_b); end
                nxt_b = ~b_ack;
            end
            if (a_ack) begin
                na++;
                checks++;
                if (a_rdata !== 16'hAAAA) begin errors++; $display("FAIL alt_a_rdata got %h want aaaa", a_rdata); end
                checks++;
                if (b_rdata !== exp_b) begin errors++; $display("FAIL alt_b_rdata_held got %h want %h", b_rdata, exp_b); end
                if (na == 8) a_req = 0;
            end
            if (b_ack) begin
                nb++;
                exp_b = 16'h5555;
                checks++;
                if (b_rdata !== 16'h5555) begin errors++; $display("FAIL alt_b_rdata got %h want 5555", b_rdata); end
                if (nb == 8) b_req = 0;
            end
        end
        a_req = 0;
        b_req = 0;
        tick;
        checks++;
        if (na !== 8 || nb !== 8) begin errors++; $display("FAIL alt_counts got %0d/%0d want 8/8", na, nb); end
        checks++;
        if (last_i !== 47) begin errors++; $display("FAIL alt_last_ack_cycle got %0d want 47", last_i); end
    endtask

    task automatic test_mid_reset;
        int lat, ld;
        logic [15:0] rd;
        {b_req, b_we, b_addr} = {1'b1, 1'b0, 6'd2};
        tick;
        reset_n = 0;
        tick;
        checks++;
        if ({a_ack, b_ack, a_rdata, b_rdata, ram_address, ram_in, ram_load} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got %h want 0", {a_ack, b_ack, a_rdata, b_rdata, ram_address, ram_in, ram_load});
        end
        b_req = 0;
        tick;
        checks++;
        if (b_ack !== 1'b0) begin errors++; $display("FAIL midrst_b_ack got %b want 0", b_ack); end
        reset_n = 1;
        tick;
        for (int i = 0; i < 100 && busy; i++) tick;
        txn(0, 0, 6'd5, 16'h0, lat, rd, ld);
        checks++;
        if (lat !== 2 || rd !== (CLR ? 16'h0000 : 16'h1234)) begin
            errors++;
            $display("FAIL midrst_read got lat %0d data %h want lat 2 data %h", lat, rd, CLR ? 16'h0000 : 16'h1234);
        end
    endtask

    task automatic test_boundary;
        int lat, ld, na = 0, nb = 0;
        logic [15:0] rd;
        txn(0, 1, 6'd63, 16'hFFFF, lat, rd, ld);
        txn(1, 1, 6'd0, 16'h0000, lat, rd, ld);
        txn(0, 0, 6'd63, 16'h0, lat, rd, ld);
        checks++;
        if (rd !== 16'hFFFF) begin errors++; $display("FAIL bound_read63 got %h want ffff", rd); end
        txn(1, 0, 6'd0, 16'h0, lat, rd, ld);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL bound_read0 got %h want 0000", rd); end
        {a_req, a_we, a_addr} = {1'b1, 1'b0, 6'd63};
        tick;
        a_req = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            na += int'(a_ack);
            nb += int'(b_ack);
        end
        checks++;
        if (na !== 1 || nb !== 0) begin errors++; $display("FAIL drop_ack_count got a=%0d b=%0d want a=1 b=0", na, nb); end
        checks++;
        if (a_rdata !== 16'hFFFF) begin errors++; $display("FAIL drop_rdata got %h want ffff", a_rdata); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        tick;
        tick;
        test_reset;
`ifdef RAM64_CLEAR_EN
        test_clear;
`else
        reset_n = 1;
        tick;
`endif
        test_write_read;
        test_contention;
        test_alternate;
        test_mid_reset;
        test_boundary;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
